fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the multi-cycle core. It replaces the inline fetch state of the control sequencer with a handshaked memory read port, tolerating any number of wait states, plus a DEPTH-entry prefetch queue. It supports redirect (jump/branch) with flush and discard of in-flight responses. It sits between the memory bus and the decode/execute sequencer, which pops instructions through a valid/ready interface.

---
 rtl/fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_fetch_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end for the multi-cycle core.
// It issues handshaked word reads and accepts any number of wait states,
// and it buffers the returned words in a DEPTH-entry prefetch queue. A
// redirect reloads the fetch address and flushes the queue. A response that
// is still in flight when the redirect arrives is drained and its data is
// discarded.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     instr_valid,
    output logic [31:0]              instr,
    output logic [ADDR_W-1:0]        instr_pc,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]     DEPTH_C    = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] RESET_ADDR = RESET_PC & WORD_MASK;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
    // The address of a request that was abandoned by a redirect. The bus
    // must keep seeing this address until the ack arrives, even though
    // fetch_pc already points at the redirect target.
    logic [ADDR_W-1:0] hold_addr_reg, hold_addr_next;
    logic [PW-1:0]     rd_ptr_reg, wr_ptr_reg;
    logic [CW-1:0]     count_reg, count_next;

    logic              push, pop;
    logic [ADDR_W-1:0] redirect_addr;

    logic [31:0]       word_arr [DEPTH];
    logic [ADDR_W-1:0] pc_arr   [DEPTH];

    assign redirect_addr = redirect_pc & WORD_MASK;

    // A redirect overrides the push and the pop that fall in the same cycle.
    assign push = (state_reg == REQ) && mem_ack && !redirect;
    assign pop  = (count_reg != '0) && instr_ready && !redirect;

    // Occupancy after this edge. The FSM uses it to decide whether a slot
    // is free, so a pop in this cycle allows the next request immediately.
    always_comb begin
        count_next = count_reg + CW'(push) - CW'(pop);
        if (redirect) begin
            count_next = '0;
        end
    end

    // Request sequencing: next state, next fetch address and held address.
    always_comb begin
        state_next     = state_reg;
        fetch_pc_next  = fetch_pc_reg;
        hold_addr_next = hold_addr_reg;
        case (state_reg)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_next = redirect_addr;
                end else if (count_next < DEPTH_C) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    fetch_pc_next = redirect_addr;
                    if (!mem_ack) begin
                        // The request is still outstanding. Drain it first.
                        state_next     = DROP;
                        hold_addr_next = fetch_pc_reg;
                    end
                end else if (mem_ack) begin
                    fetch_pc_next = fetch_pc_reg + WORD_STEP;
                    if (!(count_next < DEPTH_C)) begin
                        state_next = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect) begin
                    fetch_pc_next = redirect_addr;
                end
                if (mem_ack) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM and fetch address registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            fetch_pc_reg  <= RESET_ADDR;
            hold_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            fetch_pc_reg  <= fetch_pc_next;
            hold_addr_reg <= hold_addr_next;
        end
    end

    // Queue pointers and occupancy. A redirect returns everything to empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (redirect) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                end
            end
        end
    end

    // Queue storage. Each entry is a separate register pair so that the
    // head can be read combinationally.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
            logic [31:0]       word_reg;
            logic [ADDR_W-1:0] pc_reg;

            // Capture the returned word and its address at the write slot.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    word_reg <= '0;
                    pc_reg   <= '0;
                end else if (push && (wr_ptr_reg == PW'(gi))) begin
                    word_reg <= mem_rdata;
                    pc_reg   <= mem_addr;
                end
            end

            assign word_arr[gi] = word_reg;
            assign pc_arr[gi]   = pc_reg;
        end
    endgenerate

    assign mem_req     = (state_reg == REQ) || (state_reg == DROP);
    assign mem_addr    = (state_reg == DROP) ? hold_addr_reg : fetch_pc_reg;
    assign instr_valid = (count_reg != '0);
    assign instr       = word_arr[rd_ptr_reg];
    assign instr_pc    = pc_arr[rd_ptr_reg];
    assign count       = count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with DEPTH=4 and RESET_PC=0x100.
// The memory responder in this bench has a programmable number of wait
// states. It returns rdata = addr ^ 0xA5A5A5A5.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [2:0]  count;

    int check_cnt = 0;
    int error_cnt = 0;
    int wait_states = 0;
    int wait_cnt = 0;

    fetch_unit #(
        .ADDR_W   (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .count       (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The memory responder decides ack and data for the coming edge at each falling edge.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!mem_req) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (wait_cnt >= wait_states) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_addr ^ 32'hA5A5_A5A5;
                wait_cnt  = 0;
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end
    end

    task automatic check_value(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_cnt++;
        if (actual !== expected) begin
            error_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end else begin
            $display("ok   %s: 0x%08h", tag, actual);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        #2;
        check_value("reset mem_req", {31'd0, mem_req}, 32'd0);
        check_value("reset instr_valid", {31'd0, instr_valid}, 32'd0);
        check_value("reset count", {29'd0, count}, 32'd0);
        check_value("reset instr", instr, 32'd0);
        check_value("reset instr_pc", instr_pc, 32'd0);

        // Streaming with zero-wait memory and a consumer that is always ready.
        wait_states = 0;
        instr_ready = 1'b1;
        do_reset();
        tick();
        check_value("t1 first req", {31'd0, mem_req}, 32'd1);
        check_value("t1 first addr", mem_addr, 32'h100);
        check_value("t1 valid before ack", {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_value("t1 valid", {31'd0, instr_valid}, 32'd1);
            check_value("t1 instr_pc", instr_pc, 32'h100 + 32'(4 * i));
            check_value("t1 instr", instr, (32'h100 + 32'(4 * i)) ^ 32'hA5A5_A5A5);
            check_value("t1 count", {29'd0, count}, 32'd1);
        end

        // The queue fills, then a single pop frees one slot.
        instr_ready = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        tick();
        check_value("t2 count3", {29'd0, count}, 32'd3);
        check_value("t2 4th addr", mem_addr, 32'h10C);
        tick();
        check_value("t2 full count", {29'd0, count}, 32'd4);
        check_value("t2 full req", {31'd0, mem_req}, 32'd0);
        tick();
        check_value("t2 still idle", {31'd0, mem_req}, 32'd0);
        check_value("t2 head pc", instr_pc, 32'h100);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check_value("t2 pop count", {29'd0, count}, 32'd3);
        check_value("t2 refill req", {31'd0, mem_req}, 32'd1);
        check_value("t2 refill addr", mem_addr, 32'h110);
        check_value("t2 new head", instr_pc, 32'h104);
        tick();
        check_value("t2 refull count", {29'd0, count}, 32'd4);
        check_value("t2 refull req", {31'd0, mem_req}, 32'd0);

        // Redirect that arrives during the wait states of an outstanding request.
        wait_states = 3;
        instr_ready = 1'b1;
        do_reset();
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h2002;
        tick();
        redirect = 1'b0;
        check_value("t3 drop req", {31'd0, mem_req}, 32'd1);
        check_value("t3 drop addr hold", mem_addr, 32'h100);
        check_value("t3 flushed", {31'd0, instr_valid}, 32'd0);
        tick();
        check_value("t3 addr still held", mem_addr, 32'h100);
        tick();
        check_value("t3 new addr", mem_addr, 32'h2000);
        check_value("t3 not pushed", {29'd0, count}, 32'd0);
        tick();
        tick();
        tick();
        check_value("t3 waiting", {31'd0, instr_valid}, 32'd0);
        tick();
        check_value("t3 valid", {31'd0, instr_valid}, 32'd1);
        check_value("t3 first pc", instr_pc, 32'h2000);
        check_value("t3 first instr", instr, 32'h2000 ^ 32'hA5A5_A5A5);

        // Redirect coincident with an ack while two entries are queued.
        wait_states = 0;
        instr_ready = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        check_value("t4 count2", {29'd0, count}, 32'd2);
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h2000;
        tick();
        redirect = 1'b0;
        check_value("t4 count0", {29'd0, count}, 32'd0);
        check_value("t4 req", {31'd0, mem_req}, 32'd1);
        check_value("t4 addr", mem_addr, 32'h2000);
        tick();
        check_value("t4 pushed count", {29'd0, count}, 32'd1);
        check_value("t4 head pc", instr_pc, 32'h2000);

        // Address wrap-around at the top of the address space.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        check_value("t5 addr top", mem_addr, 32'hFFFF_FFFC);
        tick();
        check_value("t5 addr wrap", mem_addr, 32'h0000_0000);
        check_value("t5 pc top", instr_pc, 32'hFFFF_FFFC);
        check_value("t5 instr top", instr, 32'h5A5A_5A59);
        tick();
        check_value("t5 pc wrap", instr_pc, 32'h0000_0000);
        check_value("t5 instr wrap", instr, 32'hA5A5_A5A5);
        check_value("t5 addr next", mem_addr, 32'h0000_0004);

        // Asynchronous reset that arrives between clock edges during a wait state.
        wait_states = 3;
        instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        check_value("t6 count1", {29'd0, count}, 32'd1);
        tick();
        check_value("t6 waiting addr", mem_addr, 32'h104);
        #2;
        reset = 1'b1;
        #1;
        check_value("t6 async req", {31'd0, mem_req}, 32'd0);
        check_value("t6 async count", {29'd0, count}, 32'd0);
        check_value("t6 async valid", {31'd0, instr_valid}, 32'd0);
        #1;
        reset = 1'b0;
        tick();
        check_value("t6 restart req", {31'd0, mem_req}, 32'd1);
        check_value("t6 restart addr", mem_addr, 32'h100);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule
